// File: rtl/datamem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the MEM stage and the burst port.
package datamem_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int unsigned ADDR_W   = 64;
   localparam int unsigned DATA_W   = 64;
   localparam int unsigned XFER_W   = 4;
   localparam int unsigned DW_BYTES = 8;

   localparam logic [XFER_W-1:0] XFER_DW    = 4'd8;
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~64'h7;

   // One cycle's worth of datamem port signals.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic              re;
      logic [DATA_W-1:0] wdata;
      logic [XFER_W-1:0] xfer;
   } mem_req_t;

   // Doubleword address of beat idx; wraps modulo 2^64.
   function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [ADDR_W-1:0] idx);
      return base + (idx * ADDR_W'(DW_BYTES));
   endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive p0-served cycles; expired forces the next p1 beat.
module arb_wait_counter #(
   parameter int unsigned MAX_WAIT = 4,
   localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   logic [CNT_W-1:0] count;

   assign expired = (count == CNT_W'(MAX_WAIT));

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !expired) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/datamem_arbiter.sv
// Shares the datamem port between the pipeline MEM stage (priority) and a doubleword burst requester.
module datamem_arbiter
   import datamem_arb_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned LEN_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_we,
   input  logic              p0_re,
   input  logic [63:0]       p0_addr,
   input  logic [63:0]       p0_wdata,
   input  logic [3:0]        p0_xfer,
   output logic [63:0]       p0_rdata,
   output logic              p0_stall,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [63:0]       p1_addr,
   input  logic [LEN_W-1:0]  p1_len,
   input  logic [63:0]       p1_wdata,
   output logic              p1_gnt,
   output logic              p1_beat,
   output logic [63:0]       p1_rdata,
   output logic              p1_done,
   output logic [63:0]       mem_address,
   output logic              mem_write_enable,
   output logic              mem_read_enable,
   output logic [63:0]       mem_write_data,
   output logic [3:0]        mem_xfer_size,
   input  logic [63:0]       mem_read_data
);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic [63:0]       base;
   logic [LEN_W-1:0]  len;
   logic [LEN_W-1:0]  beat_cnt;
   logic              we_lat;
   logic              done_r;

   logic              p0_req;
   logic              expired;
   logic              p0_served;
   logic              beat;
   logic              gnt;
   logic              done_nxt;
   mem_req_t          req;

   assign p0_req = p0_we | p0_re;

   arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
      .clk     (clk),
      .reset   (reset),
      .clr     (beat | gnt),
      .inc     ((state == BURST) && p0_served),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and per-cycle arbitration; everything stays low while reset is held.
   always_comb begin
      state_nxt = state;
      p0_served = 1'b0;
      beat      = 1'b0;
      gnt       = 1'b0;
      done_nxt  = 1'b0;
      if (reset) begin
         case (state)
            IDLE: begin
               p0_served = p0_req;
               if (p1_req && (p1_len != '0)) begin
                  gnt       = 1'b1;
                  state_nxt = BURST;
               end
            end
            BURST: begin
               if (p0_req && !expired) begin
                  p0_served = 1'b1;
               end else begin
                  beat = 1'b1;
                  if (beat_cnt == (len - LEN_W'(1))) begin
                     state_nxt = IDLE;
                     done_nxt  = 1'b1;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Memory port mux: p0 when served, otherwise the current burst beat.
   always_comb begin
      req = '0;
      if (p0_served) begin
         req = '{addr: p0_addr, we: p0_we, re: p0_re, wdata: p0_wdata, xfer: p0_xfer};
      end else if (beat) begin
         req = '{addr:  beat_addr(base, 64'(beat_cnt)),
                 we:    we_lat,
                 re:    ~we_lat,
                 wdata: p1_wdata,
                 xfer:  XFER_DW};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         base     <= '0;
         len      <= '0;
         beat_cnt <= '0;
         we_lat   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         done_r <= done_nxt;
         if (gnt) begin
            base     <= p1_addr & ALIGN_MASK;
            len      <= p1_len;
            we_lat   <= p1_we;
            beat_cnt <= '0;
         end else if (beat) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
         end
      end
   end

   assign mem_address      = req.addr;
   assign mem_write_enable = req.we;
   assign mem_read_enable  = req.re;
   assign mem_write_data   = req.wdata;
   assign mem_xfer_size    = req.xfer;

   assign p0_stall = beat & p0_req;
   assign p0_rdata = p0_served ? mem_read_data : 64'h0;
   assign p1_gnt   = gnt;
   assign p1_beat  = beat;
   assign p1_rdata = beat ? mem_read_data : 64'h0;
   assign p1_done  = done_r & reset;

endmodule
